// File: rtl/cpu.sv
// Single-cycle 16-bit WISC processor: PC, instruction ROM, register file, ALU with Z/V/N
// flags, branch unit and data RAM. One instruction retires per rising clock edge.
module cpu #(
    parameter int unsigned IMEM_WORDS = 65536,
    parameter int unsigned DMEM_WORDS = 65536,
    parameter string       IMEM_FILE  = "instructions.img",
    parameter string       DMEM_FILE  = "data.img"
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc_out,
    output logic        hlt
);

    localparam int unsigned IW = $clog2(IMEM_WORDS);
    localparam int unsigned DW = $clog2(DMEM_WORDS);

    logic [15:0] imem [IMEM_WORDS];
    logic [15:0] dmem [DMEM_WORDS];
    logic [15:0] regs [16];

    logic [15:0] pc, pcPlus2, nextPc, instr;
    logic [3:0]  opcode, rdIdx, rsIdx, rtIdx;
    logic [15:0] rsVal, rtVal, rdVal, result, memAddr, memRdata;
    logic [15:0] addRaw, subRaw;
    logic        addOvf, subOvf;
    logic [8:0]  redSum;
    logic        flagZ, flagN, flagV;
    logic        setZ, setNV, vNew, regWe, memWe, taken;

    // 4-bit signed add, clamped to [-8, 7].
    function automatic logic [3:0] satNib(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {a[3], a} + {b[3], b};
        if (s[4] != s[3]) return s[4] ? 4'h8 : 4'h7;
        return s[3:0];
    endfunction

    function automatic logic condMet(input logic [2:0] ccc, input logic z, input logic n,
                                     input logic v);
        case (ccc)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || !n;
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    assign instr    = imem[IW'(pc[15:1])];
    assign opcode   = instr[15:12];
    assign rdIdx    = instr[11:8];
    assign rsIdx    = instr[7:4];
    assign rtIdx    = instr[3:0];
    assign rsVal    = (rsIdx == 4'd0) ? 16'h0000 : regs[rsIdx];
    assign rtVal    = (rtIdx == 4'd0) ? 16'h0000 : regs[rtIdx];
    assign rdVal    = (rdIdx == 4'd0) ? 16'h0000 : regs[rdIdx];
    assign pcPlus2  = pc + 16'd2;
    assign memAddr  = (rsVal & 16'hFFFE) + {{11{instr[3]}}, instr[3:0], 1'b0};
    assign memRdata = dmem[DW'(memAddr[15:1])];
    assign addRaw   = rsVal + rtVal;
    assign subRaw   = rsVal - rtVal;
    assign addOvf   = (rsVal[15] == rtVal[15]) && (addRaw[15] != rsVal[15]);
    assign subOvf   = (rsVal[15] != rtVal[15]) && (subRaw[15] != rsVal[15]);
    assign redSum   = {rsVal[15], rsVal[15:8]} + {rtVal[15], rtVal[15:8]}
                    + {rsVal[7], rsVal[7:0]} + {rtVal[7], rtVal[7:0]};
    assign taken    = condMet(instr[11:9], flagZ, flagN, flagV);
    assign pc_out   = pc;

    // Decode, execute and next-PC selection.
    always_comb begin
        result = 16'h0000;
        setZ   = 1'b0;
        setNV  = 1'b0;
        vNew   = 1'b0;
        regWe  = 1'b0;
        memWe  = 1'b0;
        hlt    = 1'b0;
        nextPc = pcPlus2;
        case (opcode)
            4'h0: begin
                result = addOvf ? (rsVal[15] ? 16'h8000 : 16'h7FFF) : addRaw;
                vNew   = addOvf;
                setZ   = 1'b1;
                setNV  = 1'b1;
                regWe  = 1'b1;
            end
            4'h1: begin
                result = subOvf ? (rsVal[15] ? 16'h8000 : 16'h7FFF) : subRaw;
                vNew   = subOvf;
                setZ   = 1'b1;
                setNV  = 1'b1;
                regWe  = 1'b1;
            end
            4'h2: begin result = rsVal ^ rtVal; setZ = 1'b1; regWe = 1'b1; end
            4'h3: begin result = {{7{redSum[8]}}, redSum}; regWe = 1'b1; end
            4'h4: begin result = rsVal << rtIdx; setZ = 1'b1; regWe = 1'b1; end
            4'h5: begin result = $signed(rsVal) >>> rtIdx; setZ = 1'b1; regWe = 1'b1; end
            4'h6: begin
                result = 16'({rsVal, rsVal} >> rtIdx);
                setZ   = 1'b1;
                regWe  = 1'b1;
            end
            4'h7: begin
                for (int i = 0; i < 4; i++) begin
                    result[i*4 +: 4] = satNib(rsVal[i*4 +: 4], rtVal[i*4 +: 4]);
                end
                regWe = 1'b1;
            end
            4'h8: begin result = memRdata; regWe = 1'b1; end
            4'h9: memWe = 1'b1;
            4'hA: begin result = (rdVal & 16'hFF00) | {8'h00, instr[7:0]}; regWe = 1'b1; end
            4'hB: begin result = (rdVal & 16'h00FF) | {instr[7:0], 8'h00}; regWe = 1'b1; end
            4'hC: if (taken) nextPc = pcPlus2 + {{6{instr[8]}}, instr[8:0], 1'b0};
            4'hD: if (taken) nextPc = rsVal;
            4'hE: begin result = pcPlus2; regWe = 1'b1; end
            default: begin hlt = 1'b1; nextPc = pc; end
        endcase
    end

    // PC and condition flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= 16'h0000;
            flagZ <= 1'b0;
            flagN <= 1'b0;
            flagV <= 1'b0;
        end else begin
            pc <= nextPc;
            if (setZ) flagZ <= (result == 16'h0000);
            if (setNV) begin
                flagN <= result[15];
                flagV <= vNew;
            end
        end
    end

    // Register file write-back; R0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
        end else if (regWe && rdIdx != 4'd0) begin
            regs[rdIdx] <= result;
        end
    end

    // Data memory store; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && memWe) dmem[DW'(memAddr[15:1])] <= rdVal;
    end

endmodule

// File: tb/tb_cpu.sv
// Directed program test for the WISC cpu: preloads a program, traces the PC every cycle and
// checks register, flag and memory state at key points.
module tb_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_out;
    logic        hlt;
    int          vectors = 0;
    int          errors  = 0;

    cpu #(.IMEM_FILE(""), .DMEM_FILE("")) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_out (pc_out),
        .hlt    (hlt)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [25] = '{
        16'hA1FF, 16'hB17F, 16'hA201, 16'hB200, 16'h0312, 16'hA403, 16'h1442, 16'hC1FE,
        16'hA510, 16'h9152, 16'h8652, 16'hA811, 16'h8982, 16'h2A12, 16'h0011, 16'h4C14,
        16'hE700, 16'h0FF2, 16'h1EF2, 16'hC001, 16'hDE70, 16'h5DC4, 16'h6B21, 16'h7411,
        16'hF000
    };
    logic [15:0] seq [32] = '{
        16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h0A, 16'h0C, 16'h0E,
        16'h0C, 16'h0E, 16'h0C, 16'h0E, 16'h10, 16'h12, 16'h14, 16'h16,
        16'h18, 16'h1A, 16'h1C, 16'h1E, 16'h20, 16'h22, 16'h24, 16'h26,
        16'h28, 16'h22, 16'h24, 16'h26, 16'h2A, 16'h2C, 16'h2E, 16'h30
    };
    logic [15:0] finalRegs [16] = '{
        16'h0000, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h7EEE, 16'h0010, 16'h7FFF, 16'h0022,
        16'h0011, 16'h7FFF, 16'h7FFE, 16'h8000, 16'hFFF0, 16'hFFFF, 16'h0001, 16'h0002
    };

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 25; i++) dut.imem[i] = prog[i];
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", pc_out, 16'h0000);
        check("reset hlt", {15'd0, hlt}, 16'h0000);
        for (int r = 1; r < 16; r++) check($sformatf("reset R%0d", r), dut.regs[r], 16'h0000);
        rst = 1'b0;

        for (int k = 0; k < 32; k++) begin
            check($sformatf("pc step %0d", k), pc_out, seq[k]);
            check($sformatf("hlt step %0d", k), {15'd0, hlt}, {15'd0, seq[k] == 16'h30});
            if (k == 5) begin
                check("R1 after LLB/LHB", dut.regs[1], 16'h7FFF);
                check("R2 after LLB/LHB", dut.regs[2], 16'h0001);
                check("R3 saturated add", dut.regs[3], 16'h7FFF);
                check("V after saturated add", {15'd0, dut.flagV}, 16'h0001);
            end
            if (k == 12) begin
                check("R4 loop exit", dut.regs[4], 16'h0000);
                check("Z loop exit", {15'd0, dut.flagZ}, 16'h0001);
            end
            if (k == 15) begin
                check("dmem[10] after SW", dut.dmem[10], 16'h7FFF);
                check("R6 after LW", dut.regs[6], 16'h7FFF);
            end
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 5; k++) begin
            check("halt pc", pc_out, 16'h0030);
            check("halt hlt", {15'd0, hlt}, 16'h0001);
            @(posedge clk);
            #1;
        end
        for (int r = 0; r < 16; r++) check($sformatf("final R%0d", r), dut.regs[r], finalRegs[r]);
        check("final flags ZNV", {13'd0, dut.flagZ, dut.flagN, dut.flagV}, 16'h0000);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rerst pc", pc_out, 16'h0000);
        check("rerst hlt", {15'd0, hlt}, 16'h0000);
        check("rerst R1", dut.regs[1], 16'h0000);
        check("rerst dmem kept", dut.dmem[10], 16'h7FFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
